// File: rtl/layer_sequencer.sv
// layer_sequencer: gathers one value per upstream neuron lane, then replays the
// collected values to the downstream layer's serial input, lowest index first,
// one beat per clock for NUM_IN consecutive beats, then re-arms for the next frame.
//
//   state   | meaning
//   --------+-----------------------------------------------------------------
//   COLLECT | latch lane values on prev_valid, wait until every lane has reported
//   STREAM  | emit data_buf[idx] each cycle; upstream valids are dropped and flagged
module layer_sequencer #(
    parameter int NUM_IN    = 30,
    parameter int dataWidth = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_IN-1:0]           prev_valid,
    input  logic [NUM_IN*dataWidth-1:0] prev_data,
    output logic                        next_valid,
    output logic [dataWidth-1:0]        next_data,
    output logic                        busy,
    output logic                        frame_done,
    output logic                        overrun
);

    localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_IN - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        STREAM  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_IN-1:0]    mask_q, mask_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [dataWidth-1:0] data_buf [NUM_IN];

    logic                 next_valid_d;
    logic [dataWidth-1:0] next_data_d;
    logic                 frame_done_d;
    logic                 overrun_d;

    // State, counters and registered outputs; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= COLLECT;
            mask_q     <= '0;
            idx_q      <= '0;
            next_valid <= 1'b0;
            next_data  <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            idx_q      <= idx_d;
            next_valid <= next_valid_d;
            next_data  <= next_data_d;
            frame_done <= frame_done_d;
            overrun    <= overrun_d;
        end
    end

    // Lane capture while collecting; a repeated valid on a lane simply overwrites it.
    // The buffer carries no reset since its contents are only read after a full collect.
    always_ff @(posedge clk) begin
        if (state_q == COLLECT) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (prev_valid[i]) begin
                    data_buf[i] <= prev_data[i*dataWidth +: dataWidth];
                end
            end
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        idx_d        = idx_q;
        next_valid_d = 1'b0;
        next_data_d  = next_data;
        frame_done_d = 1'b0;
        overrun_d    = overrun;
        case (state_q)
            COLLECT: begin
                // Lanes arriving on this edge count toward completion, so the stream
                // starts the edge after the final lane shows up.
                mask_d = mask_q | prev_valid;
                if (mask_d == {NUM_IN{1'b1}}) begin
                    state_d = STREAM;
                    idx_d   = '0;
                end
            end
            STREAM: begin
                next_valid_d = 1'b1;
                next_data_d  = data_buf[idx_q];
                if (|prev_valid) begin
                    overrun_d = 1'b1;
                end
                if (idx_q == IDX_LAST) begin
                    frame_done_d = 1'b1;
                    mask_d       = '0;
                    idx_d        = '0;
                    state_d      = COLLECT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    assign busy = (state_q == STREAM);

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: a 4-lane instance for hand-computed frames
// and a 30-lane instance driven with randomised frames against a scoreboard.
module tb_layer_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [3:0]  pv;
    logic [63:0] pd;
    logic        nv;
    logic [15:0] nd;
    logic        busy;
    logic        fd;
    logic        ovr;

    logic [29:0]  pv30;
    logic [479:0] pd30;
    logic         nv30;
    logic [15:0]  nd30;
    logic         busy30;
    logic         fd30;
    logic         ovr30;

    int n_cmp = 0;
    int n_err = 0;

    layer_sequencer #(.NUM_IN(4), .dataWidth(16)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .prev_valid (pv),
        .prev_data  (pd),
        .next_valid (nv),
        .next_data  (nd),
        .busy       (busy),
        .frame_done (fd),
        .overrun    (ovr)
    );

    layer_sequencer #(.NUM_IN(30), .dataWidth(16)) u_dut30 (
        .clk        (clk),
        .rst_n      (rst_n),
        .prev_valid (pv30),
        .prev_data  (pd30),
        .next_valid (nv30),
        .next_data  (nd30),
        .busy       (busy30),
        .frame_done (fd30),
        .overrun    (ovr30)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
        n_cmp++;
        if (obs !== exp_val) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input logic [63:0] d);
        pv = v;
        pd = d;
    endtask

    // Called in the cycle after the final lane was presented (state already STREAM).
    // Returns in the frame_done cycle with inputs cleared.
    task automatic stream4(input string tag, input logic [63:0] exp_vals);
        chk({tag, "_pre_nv"}, 32'(nv), 32'd0);
        chk({tag, "_pre_busy"}, 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            drive(4'b0000, 64'h0);
            chk($sformatf("%s_nv%0d", tag, i), 32'(nv), 32'd1);
            chk($sformatf("%s_nd%0d", tag, i), 32'(nd), 32'(exp_vals[i*16 +: 16]));
            chk($sformatf("%s_fd%0d", tag, i), 32'(fd), 32'(i == 3));
            chk($sformatf("%s_busy%0d", tag, i), 32'(busy), 32'(i != 3));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [15:0] exp30 [30];
    logic [29:0] got30;
    logic [29:0] v30;
    logic [15:0] val;

    initial begin
        rst_n = 1'b0;
        pv    = '0;
        pd    = '0;
        pv30  = '0;
        pd30  = '0;
        tick();
        tick();
        chk("rst_nv", 32'(nv), 32'd0);
        chk("rst_nd", 32'(nd), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fd", 32'(fd), 32'd0);
        chk("rst_ovr", 32'(ovr), 32'd0);
        chk("rst30_nv", 32'(nv30), 32'd0);
        chk("rst30_busy", 32'(busy30), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_nv", 32'(nv), 32'd0);

        // all lanes in one cycle
        drive(4'hF, 64'h0004_0003_0002_0001);
        tick();
        drive(4'h0, 64'h0);
        stream4("t1", 64'h0004_0003_0002_0001);
        chk("t1_ovr", 32'(ovr), 32'd0);
        tick();
        chk("t1_post_nv", 32'(nv), 32'd0);
        chk("t1_post_nd_hold", 32'(nd), 32'h0004);
        chk("t1_post_fd", 32'(fd), 32'd0);

        // staggered lanes, lane0 rewritten before completion
        for (int c = 0; c < 10; c++) begin
            case (c)
                0:       drive(4'b0100, 64'hDEAD_2222_BEEF_CAFE);
                3:       drive(4'b0001, 64'hFFFF_FFFF_FFFF_AAAA);
                4:       drive(4'b0001, 64'h0000_0000_0000_1111);
                5:       drive(4'b1000, 64'h3333_0000_0000_0000);
                9:       drive(4'b0010, 64'h0000_0000_5555_0000);
                default: drive(4'b0000, 64'hFFFF_FFFF_FFFF_FFFF);
            endcase
            tick();
            if (c < 9) begin
                chk($sformatf("t2_quiet_nv_c%0d", c + 1), 32'(nv), 32'd0);
                chk($sformatf("t2_quiet_busy_c%0d", c + 1), 32'(busy), 32'd0);
            end
        end
        drive(4'h0, 64'h0);
        stream4("t2", 64'h3333_2222_5555_1111);

        // back-to-back frames accepted in the frame_done cycle
        drive(4'hF, 64'h0008_0007_0006_0005);
        tick();
        drive(4'h0, 64'h0);
        stream4("t4a", 64'h0008_0007_0006_0005);
        drive(4'hF, 64'h000C_000B_000A_0009);
        tick();
        drive(4'h0, 64'h0);
        stream4("t4b", 64'h000C_000B_000A_0009);
        chk("t4_ovr", 32'(ovr), 32'd0);
        tick();

        // upstream valid while streaming is dropped and flagged
        drive(4'hF, 64'h0044_0033_0022_0011);
        tick();
        drive(4'b0001, 64'h0000_0000_0000_DEAD);
        stream4("t3", 64'h0044_0033_0022_0011);
        chk("t3_ovr_set", 32'(ovr), 32'd1);
        tick();
        drive(4'hF, 64'h0404_0303_0202_0101);
        tick();
        drive(4'h0, 64'h0);
        stream4("t3b", 64'h0404_0303_0202_0101);
        chk("t3_ovr_sticky", 32'(ovr), 32'd1);
        tick();

        // reset mid-stream after beat 2
        drive(4'hF, 64'h00D4_00D3_00D2_00D1);
        tick();
        drive(4'h0, 64'h0);
        tick();
        tick();
        chk("t5_beat2_nv", 32'(nv), 32'd1);
        chk("t5_beat2_nd", 32'(nd), 32'h00D2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t5_rst_nv", 32'(nv), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_ovr", 32'(ovr), 32'd0);
        chk("t5_rst_fd", 32'(fd), 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("t5_abort_nv%0d", c), 32'(nv), 32'd0);
        end

        // partial mask discarded by reset
        drive(4'b0011, 64'h0000_0000_00B2_00B1);
        tick();
        drive(4'h0, 64'h0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drive(4'b1100, 64'h00E4_00E3_0000_0000);
        tick();
        drive(4'h0, 64'h0);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("t5_partial_nv%0d", c), 32'(nv), 32'd0);
            chk($sformatf("t5_partial_busy%0d", c), 32'(busy), 32'd0);
        end
        drive(4'b0011, 64'h0000_0000_00E2_00E1);
        tick();
        drive(4'h0, 64'h0);
        stream4("t5", 64'h00E4_00E3_00E2_00E1);
        chk("t5_ovr", 32'(ovr), 32'd0);

        // 30 lanes, randomised arrival and data, scoreboard per frame
        for (int f = 0; f < 100; f++) begin
            got30 = '0;
            for (int c = 0; c < 200; c++) begin
                v30 = '0;
                for (int i = 0; i < 30; i++) begin
                    if ($urandom_range(3) == 0) v30[i] = 1'b1;
                end
                if (c >= 20) v30 = v30 | ~got30;
                for (int i = 0; i < 30; i++) begin
                    if (v30[i]) begin
                        val = 16'($urandom_range(65535));
                        exp30[i] = val;
                        pd30[i*16 +: 16] = val;
                    end else begin
                        pd30[i*16 +: 16] = 16'($urandom);
                    end
                end
                pv30  = v30;
                got30 = got30 | v30;
                tick();
                pv30 = '0;
                if (got30 == {30{1'b1}}) break;
                chk($sformatf("t6_f%0d_quiet_nv", f), 32'(nv30), 32'd0);
                chk($sformatf("t6_f%0d_quiet_busy", f), 32'(busy30), 32'd0);
            end
            chk($sformatf("t6_f%0d_pre_busy", f), 32'(busy30), 32'd1);
            chk($sformatf("t6_f%0d_pre_nv", f), 32'(nv30), 32'd0);
            for (int b = 0; b < 30; b++) begin
                tick();
                chk($sformatf("t6_f%0d_nv%0d", f, b), 32'(nv30), 32'd1);
                chk($sformatf("t6_f%0d_nd%0d", f, b), 32'(nd30), 32'(exp30[b]));
                chk($sformatf("t6_f%0d_fd%0d", f, b), 32'(fd30), 32'(b == 29));
                chk($sformatf("t6_f%0d_busy%0d", f, b), 32'(busy30), 32'(b != 29));
            end
        end
        chk("t6_ovr", 32'(ovr30), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
